// File: rtl/fb_loader.sv
// fb_loader: host-link frame loader for the HUB75 row-scan driver.
//
// Accepts a framed byte stream (SYNC_BYTE, then WORDS little-endian 16-bit pixel words), writes
// each word into the back bank of a double-buffered frame memory and, once the frame is complete,
// requests a bank swap. The scan driver acknowledges at its own end of frame, so the display never
// shows a torn image. A stalled host link aborts the frame after TIMEOUT idle cycles.
//
// Ports:
//   clk, rst              system clock; asynchronous active-high reset
//   rx_data/rx_valid      incoming byte and its valid
//   rx_ready              loader can accept a byte (low only while a swap is pending)
//   fb_wen/fb_addr        frame memory write strobe (one cycle per word) and word address
//   fb_wdata              pixel word {hi, lo}
//   fb_bank               bank being written (always the bank not on display)
//   display_bank          bank the scan driver must read
//   swap_req/swap_ack     frame complete / scan driver accepts the swap
//   frame_done            one-cycle pulse when a swap completes
//   err_timeout           one-cycle pulse when a frame is aborted by the idle timeout
module fb_loader #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned WORDS     = 256,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 50000,
   parameter int unsigned TO_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              fb_wen,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [15:0]       fb_wdata,
   output logic              fb_bank,
   output logic              display_bank,
   output logic              swap_req,
   input  logic              swap_ack,
   output logic              frame_done,
   output logic              err_timeout
);

   localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(WORDS - 1);
   localparam logic [TO_W-1:0]   ToLast   = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLo, StHi, StSwap} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [7:0]        lo_q, lo_d;
   logic              fb_wen_d;
   logic [ADDR_W-1:0] fb_addr_d;
   logic [15:0]       fb_wdata_d;
   logic              swap_req_d, frame_done_d, err_timeout_d, display_bank_d;
   logic              accept;
   logic              to_hit;

   // Held low during reset so no byte is consumed while the loader is being cleared.
   assign rx_ready = ~rst & (state_q != StSwap);
   assign accept   = rx_valid & rx_ready;
   assign fb_bank  = ~display_bank;
   assign to_hit   = (to_cnt_q == ToLast);

   always_comb begin
      state_d        = state_q;
      word_cnt_d     = word_cnt_q;
      to_cnt_d       = '0;              // cleared on any accepted byte and outside LO/HI
      lo_d           = lo_q;
      fb_wen_d       = 1'b0;
      fb_addr_d      = fb_addr;
      fb_wdata_d     = fb_wdata;
      swap_req_d     = 1'b0;
      frame_done_d   = 1'b0;
      err_timeout_d  = 1'b0;
      display_bank_d = display_bank;

      unique case (state_q)
         StIdle: begin
            if (accept && rx_data == SYNC_BYTE) begin
               state_d    = StLo;
               word_cnt_d = '0;
            end
         end
         StLo: begin
            if (accept) begin
               lo_d    = rx_data;
               state_d = StHi;
            end else if (to_hit) begin
               err_timeout_d = 1'b1;
               state_d       = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         StHi: begin
            if (accept) begin
               fb_wen_d   = 1'b1;
               fb_addr_d  = word_cnt_q;
               fb_wdata_d = {rx_data, lo_q};
               if (word_cnt_q == LastWord) begin
                  state_d = StSwap;
               end else begin
                  word_cnt_d = word_cnt_q + ADDR_W'(1);
                  state_d    = StLo;
               end
            end else if (to_hit) begin
               err_timeout_d = 1'b1;
               state_d       = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         StSwap: begin
            // Ack only counts once swap_req is visible, so an ack already high on entry
            // completes the swap one cycle after swap_req rises.
            if (swap_req && swap_ack) begin
               display_bank_d = ~display_bank;
               frame_done_d   = 1'b1;
               state_d        = StIdle;
            end else begin
               swap_req_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         word_cnt_q   <= '0;
         to_cnt_q     <= '0;
         lo_q         <= '0;
         fb_wen       <= 1'b0;
         fb_addr      <= '0;
         fb_wdata     <= '0;
         swap_req     <= 1'b0;
         frame_done   <= 1'b0;
         err_timeout  <= 1'b0;
         display_bank <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         to_cnt_q     <= to_cnt_d;
         lo_q         <= lo_d;
         fb_wen       <= fb_wen_d;
         fb_addr      <= fb_addr_d;
         fb_wdata     <= fb_wdata_d;
         swap_req     <= swap_req_d;
         frame_done   <= frame_done_d;
         err_timeout  <= err_timeout_d;
         display_bank <= display_bank_d;
      end
   end

endmodule

// File: tb/tb_fb_loader.sv
// Randomized scoreboard bench for fb_loader (WORDS=4, TIMEOUT=8).
module tb_fb_loader;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned WORDS   = 4;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned TO_W    = 16;
   localparam logic [7:0]  SYNC    = 8'hA5;

   logic              clk;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              fb_wen;
   logic [ADDR_W-1:0] fb_addr;
   logic [15:0]       fb_wdata;
   logic              fb_bank;
   logic              display_bank;
   logic              swap_req;
   logic              swap_ack;
   logic              frame_done;
   logic              err_timeout;

   fb_loader #(
      .ADDR_W   (ADDR_W),
      .WORDS    (WORDS),
      .SYNC_BYTE(SYNC),
      .TIMEOUT  (TIMEOUT),
      .TO_W     (TO_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .fb_wen      (fb_wen),
      .fb_addr     (fb_addr),
      .fb_wdata    (fb_wdata),
      .fb_bank     (fb_bank),
      .display_bank(display_bank),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .frame_done  (frame_done),
      .err_timeout (err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EvWr, EvDone, EvErr} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       cyc;
      int       addr;
      int       data;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   // Reference model: frame position in bytes, idle cycles since the last byte, swap age.
   bit       m_in_frame = 0;
   bit       m_swapping = 0;
   bit       m_bank     = 0;
   int       m_nbytes   = 0;
   int       m_idle     = 0;
   int       m_age      = 0;
   bit [7:0] m_lo       = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input ev_kind_e k, input int addr, input int data);
      ev_t e;
      e.kind = k;
      e.cyc  = cyc + 1;  // output visible in the cycle after this edge
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // One clock edge of the reference model, called just after posedge with the driven inputs.
   task automatic model_edge(input bit v, input bit [7:0] d, input bit a);
      bit acc;
      acc = v && !m_swapping;
      if (m_swapping) begin
         if (a && m_age >= 1) begin
            m_swapping = 0;
            m_bank     = !m_bank;
            push(EvDone, 0, 0);
         end else begin
            m_age++;
         end
      end else if (!m_in_frame) begin
         if (acc && d == SYNC) begin
            m_in_frame = 1;
            m_nbytes   = 0;
            m_idle     = 0;
         end
      end else if (acc) begin
         if (m_nbytes % 2 == 0) begin
            m_lo = d;
         end else begin
            push(EvWr, m_nbytes / 2, int'({d, m_lo}));
            if (m_nbytes / 2 == int'(WORDS) - 1) begin
               m_in_frame = 0;
               m_swapping = 1;
               m_age      = 0;
            end
         end
         m_nbytes++;
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle == int'(TIMEOUT)) begin
            m_in_frame = 0;
            push(EvErr, 0, 0);
         end
      end
   endtask

   // Called at a negedge; returns at the next negedge after checking level outputs.
   task automatic step(input bit v, input bit [7:0] d, input bit a);
      rx_valid = v;
      rx_data  = d;
      swap_ack = a;
      check("rx_ready", 32'(rx_ready), 32'(!m_swapping));
      @(posedge clk);
      model_edge(v, d, a);
      @(negedge clk);
      check("swap_req", 32'(swap_req), 32'(m_swapping && m_age >= 1));
      check("display_bank", 32'(display_bank), 32'(m_bank));
      check("fb_bank", 32'(fb_bank), 32'(!m_bank));
   endtask

   task automatic send(input bit [7:0] b);
      step(1'b1, b, 1'b0);
   endtask

   task automatic idle(input int n, input bit a);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
   endtask

   task automatic finish_swap();
      for (int i = 0; i < 10 && m_swapping; i++) step(1'b0, 8'h00, 1'b1);
      check("swap_finished", 32'(m_swapping), 32'(0));
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check("pending_at_reset", 32'(exp_q.size()), 32'(0));
      check("rst_fb_wen", 32'(fb_wen), 32'(0));
      check("rst_fb_addr", 32'(fb_addr), 32'(0));
      check("rst_fb_wdata", 32'(fb_wdata), 32'(0));
      check("rst_swap_req", 32'(swap_req), 32'(0));
      check("rst_display_bank", 32'(display_bank), 32'(0));
      check("rst_fb_bank", 32'(fb_bank), 32'(1));
      check("rst_rx_ready", 32'(rx_ready), 32'(0));
      check("rst_frame_done", 32'(frame_done), 32'(0));
      check("rst_err_timeout", 32'(err_timeout), 32'(0));
      m_in_frame = 0;
      m_swapping = 0;
      m_bank     = 0;
      exp_q.delete();
      rx_valid = 1'b0;
      swap_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_rx_ready", 32'(rx_ready), 32'(1));
   endtask

   // Monitor: pops the expected event due this cycle and checks the pulse outputs against it.
   logic [31:0] last_addr, last_data;
   always @(negedge clk) begin : monitor
      ev_t e;
      bit  have;
      have = 0;
      if (rst) begin
         last_addr = 0;
         last_data = 0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_event", 32'(e.cyc), 32'(cyc));
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e    = exp_q.pop_front();
            have = 1;
         end
         check("fb_wen", 32'(fb_wen), 32'(have && e.kind == EvWr));
         check("frame_done", 32'(frame_done), 32'(have && e.kind == EvDone));
         check("err_timeout", 32'(err_timeout), 32'(have && e.kind == EvErr));
         if (have && e.kind == EvWr) begin
            check("fb_addr", 32'(fb_addr), 32'(e.addr));
            check("fb_wdata", 32'(fb_wdata), 32'(e.data));
            last_addr = 32'(e.addr);
            last_data = 32'(e.data);
         end else begin
            check("fb_addr_hold", 32'(fb_addr), last_addr);
            check("fb_wdata_hold", 32'(fb_wdata), last_data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit [7:0] frame_a [9];
      int       gap;
      bit       v, a;
      bit [7:0] d;
      frame_a = '{8'hA5, 8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04, 8'h40};
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      swap_ack = 1'b0;
      @(negedge clk);
      do_reset();

      // Full frame, ack 5 cycles after swap_req rises.
      foreach (frame_a[i]) send(frame_a[i]);
      idle(6, 1'b0);
      finish_swap();
      idle(2, 1'b0);

      // Pre-sync garbage, then a frame with ack already high on entry to SWAP.
      send(8'h00); send(8'hFF); send(8'h5A); send(SYNC);
      for (int i = 0; i < 2 * int'(WORDS); i++) send(8'($urandom));
      idle(4, 1'b1);

      // Timeout after one and a half words, then a fresh frame restarts at address 0.
      send(SYNC); send(8'h11); send(8'h22); send(8'h33);
      idle(12, 1'b0);
      send(SYNC); send(8'h44); send(8'h55);
      idle(12, 1'b0);

      // Backpressure during SWAP; the held byte is taken in IDLE afterwards and discarded.
      send(SYNC);
      for (int i = 0; i < 2 * int'(WORDS); i++) send(8'($urandom));
      for (int i = 0; i < 4; i++) step(1'b1, 8'h77, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b1);
      idle(2, 1'b0);

      // Reset while in HI after two words, then a complete frame.
      send(SYNC);
      for (int i = 0; i < 5; i++) send(8'($urandom));
      do_reset();
      send(SYNC);
      for (int i = 0; i < 2 * int'(WORDS); i++) send(8'($urandom));
      finish_swap();

      // Random traffic, with occasional idle gaps straddling the timeout boundary.
      gap = 0;
      for (int i = 0; i < 4000; i++) begin
         if (gap > 0) begin
            gap--;
            step(1'b0, 8'h00, ($urandom % 3) == 0);
         end else begin
            if ($urandom % 120 == 0) gap = int'(TIMEOUT) - 1 + int'($urandom % 4);
            v = ($urandom % 4) != 0;
            d = (!m_in_frame && ($urandom % 2) == 0) ? SYNC : 8'($urandom);
            a = ($urandom % 3) == 0;
            step(v, d, a);
         end
      end

      for (int i = 0; i < 40 && (exp_q.size() > 0 || m_swapping); i++) step(1'b0, 8'h00, 1'b1);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
